// File: rtl/csr_pkg.sv
// Shared CSR addresses, interrupt cause codes, mstatus bit positions and
// the enums used by the M-mode CSR file and trap controller.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET = 12'hB02;
   localparam logic [11:0] CSR_MHARTID  = 12'hF14;

   localparam logic [3:0] IRQ_MSI = 4'd3;
   localparam logic [3:0] IRQ_MTI = 4'd7;
   localparam logic [3:0] IRQ_MEI = 4'd11;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   typedef enum logic [1:0] {
      CSR_NONE = 2'b00,
      CSR_RW   = 2'b01,
      CSR_RS   = 2'b10,
      CSR_RC   = 2'b11
   } csr_op_e;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } state_e;

endpackage

// File: rtl/irq_sync.sv
// Flop-chain synchroniser for one asynchronous interrupt level. Also exposes
// the value the output will take after the next edge.
module irq_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic sync_o,
   output logic sync_nxt_o
);

   logic [STAGES-1:0] chain_q, chain_d;

   always_comb begin
      chain_d[0] = async_i;
      for (int i = 1; i < STAGES; i++) chain_d[i] = chain_q[i-1];
   end

   always_ff @(posedge clk) begin
      if (reset) chain_q <= '0;
      else       chain_q <= chain_d;
   end

   assign sync_o     = chain_q[STAGES-1];
   assign sync_nxt_o = chain_d[STAGES-1];

endmodule

// File: rtl/csr_trap_ctrl.sv
// M-mode CSR file and writeback-stage trap/interrupt controller: CSR access,
// interrupt arbitration, trap entry / mret sequencing and a held fetch redirect.
module csr_trap_ctrl
   import csr_pkg::*;
#(
   parameter int XLEN            = 64,
   parameter int IRQ_SYNC_STAGES = 2,
   parameter bit HAS_COUNTERS    = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wb_valid,
   input  logic [XLEN-1:0] wb_pc,
   input  logic [1:0]      csr_op,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   input  logic            except_valid,
   input  logic [XLEN-1:0] except_cause,
   input  logic [XLEN-1:0] except_tval,
   input  logic            mret,
   input  logic            irq_msip,
   input  logic            irq_mtip,
   input  logic            irq_meip,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   output logic            flush,
   output logic            stall,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   input  logic            redirect_ready,
   output logic [XLEN-1:0] mstatus_diff,
   output logic [XLEN-1:0] mie_diff,
   output logic [XLEN-1:0] mip_diff,
   output logic [XLEN-1:0] mtvec_diff,
   output logic [XLEN-1:0] mepc_diff,
   output logic [XLEN-1:0] mcause_diff,
   output logic [XLEN-1:0] mtval_diff,
   output logic [XLEN-1:0] mscratch_diff
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   // Interrupt bit vectors are kept as {MEI, MTI, MSI}.
   function automatic logic [XLEN-1:0] irq_vec(input logic [2:0] b);
      irq_vec          = '0;
      irq_vec[IRQ_MSI] = b[0];
      irq_vec[IRQ_MTI] = b[1];
      irq_vec[IRQ_MEI] = b[2];
   endfunction

   function automatic logic [XLEN-1:0] mstatus_vec(input logic mie, input logic mpie);
      mstatus_vec                                = '0;
      mstatus_vec[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      mstatus_vec[MSTATUS_MIE]                   = mie;
      mstatus_vec[MSTATUS_MPIE]                  = mpie;
   endfunction

   csr_op_e         op_e;
   state_e          state_q;
   logic            redirect_valid_q;
   logic [XLEN-1:0] redirect_pc_q;

   logic            mstatus_mie_q, mstatus_mie_d;
   logic            mstatus_mpie_q, mstatus_mpie_d;
   logic [2:0]      mie_en_q, mie_en_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic [XLEN-1:0] mtval_q, mtval_d;
   logic [XLEN-1:0] mcycle_val, minstret_val;

   logic [2:0]      irq_raw, mip_s, mip_nxt;
   logic [2:0]      pend;
   logic            irq_take, trap, mret_go, csr_we, retire, idle, csr_hit;
   logic [3:0]      irq_code;
   logic [XLEN-1:0] csr_wval, trap_cause, trap_tval, trap_vec, mtvec_base;

   assign op_e    = csr_op_e'(csr_op);
   assign irq_raw = {irq_meip, irq_mtip, irq_msip};

   for (genvar g = 0; g < 3; g++) begin : g_sync
      irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_sync (
         .clk        (clk),
         .reset      (reset),
         .async_i    (irq_raw[g]),
         .sync_o     (mip_s[g]),
         .sync_nxt_o (mip_nxt[g])
      );
   end

   always_comb begin
      csr_hit   = 1'b1;
      csr_rdata = '0;
      case (csr_addr)
         CSR_MSTATUS:  csr_rdata = mstatus_vec(mstatus_mie_q, mstatus_mpie_q);
         CSR_MIE:      csr_rdata = irq_vec(mie_en_q);
         CSR_MTVEC:    csr_rdata = mtvec_q;
         CSR_MSCRATCH: csr_rdata = mscratch_q;
         CSR_MEPC:     csr_rdata = mepc_q;
         CSR_MCAUSE:   csr_rdata = mcause_q;
         CSR_MTVAL:    csr_rdata = mtval_q;
         CSR_MIP:      csr_rdata = irq_vec(mip_s);
         CSR_MCYCLE:   csr_rdata = mcycle_val;
         CSR_MINSTRET: csr_rdata = minstret_val;
         CSR_MHARTID:  csr_rdata = '0;
         default:      csr_hit   = 1'b0;
      endcase
   end

   // Legality only matters for an actual CSR instruction.
   assign csr_illegal = (op_e != CSR_NONE) && (!csr_hit || (csr_addr[11:10] == 2'b11));

   always_comb begin
      case (op_e)
         CSR_RW:  csr_wval = csr_wdata;
         CSR_RS:  csr_wval = csr_rdata | csr_wdata;
         CSR_RC:  csr_wval = csr_rdata & ~csr_wdata;
         default: csr_wval = csr_rdata;
      endcase
   end

   assign pend     = mip_s & mie_en_q;
   assign irq_take = mstatus_mie_q && (|pend);
   assign irq_code = pend[2] ? IRQ_MEI : (pend[0] ? IRQ_MSI : IRQ_MTI);

   assign idle    = (state_q == ST_IDLE);
   assign trap    = wb_valid && idle && (irq_take || except_valid);
   assign mret_go = wb_valid && idle && mret && !trap;
   assign retire  = wb_valid && idle && !trap;
   assign csr_we  = retire && (op_e != CSR_NONE) && !csr_illegal;

   always_comb begin
      trap_cause           = except_cause;
      if (irq_take) begin
         trap_cause        = '0;
         trap_cause[XLEN-1] = 1'b1;
         trap_cause[3:0]   = irq_code;
      end
   end

   assign trap_tval  = irq_take ? '0 : except_tval;
   assign mtvec_base = mtvec_q & ALIGN_MASK;
   // Only mode 01 vectors, and only for interrupts; mode 1x falls back to direct.
   assign trap_vec   = (irq_take && (mtvec_q[1:0] == 2'b01))
                     ? mtvec_base + XLEN'({irq_code, 2'b00}) : mtvec_base;

   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_en_d       = mie_en_q;
      mtvec_d        = mtvec_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mtval_d        = mtval_q;
      if (trap) begin
         mepc_d         = wb_pc & ALIGN_MASK;
         mcause_d       = trap_cause;
         mtval_d        = trap_tval;
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (mret_go) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end else if (csr_we) begin
         case (csr_addr)
            CSR_MSTATUS: begin
               mstatus_mie_d  = csr_wval[MSTATUS_MIE];
               mstatus_mpie_d = csr_wval[MSTATUS_MPIE];
            end
            CSR_MIE:      mie_en_d   = {csr_wval[IRQ_MEI], csr_wval[IRQ_MTI], csr_wval[IRQ_MSI]};
            CSR_MTVEC:    mtvec_d    = csr_wval;
            CSR_MSCRATCH: mscratch_d = csr_wval;
            CSR_MEPC:     mepc_d     = csr_wval & ALIGN_MASK;
            CSR_MCAUSE:   mcause_d   = csr_wval;
            CSR_MTVAL:    mtval_d    = csr_wval;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_en_q       <= '0;
         mtvec_q        <= '0;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_en_q       <= mie_en_d;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mtval_q        <= mtval_d;
      end
   end

   if (HAS_COUNTERS) begin : g_cnt
      logic [XLEN-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
      // A CSR write replaces the increment for that cycle.
      assign mcycle_d   = (csr_we && csr_addr == CSR_MCYCLE)   ? csr_wval : mcycle_q + XLEN'(1);
      assign minstret_d = (csr_we && csr_addr == CSR_MINSTRET) ? csr_wval : minstret_q + XLEN'(retire);
      always_ff @(posedge clk) begin
         if (reset) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
         end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
         end
      end
      assign mcycle_val   = mcycle_q;
      assign minstret_val = minstret_q;
   end else begin : g_nocnt
      assign mcycle_val   = '0;
      assign minstret_val = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (trap || mret_go) begin
                  state_q          <= ST_REDIRECT;
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= trap ? trap_vec : mepc_q;
               end
            end
            ST_REDIRECT: begin
               if (redirect_ready) begin
                  state_q          <= ST_IDLE;
                  redirect_valid_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign flush          = trap || mret_go;
   assign stall          = (state_q == ST_REDIRECT);
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

   assign mstatus_diff  = mstatus_vec(mstatus_mie_d, mstatus_mpie_d);
   assign mie_diff      = irq_vec(mie_en_d);
   assign mip_diff      = irq_vec(mip_nxt);
   assign mtvec_diff    = mtvec_d;
   assign mepc_diff     = mepc_d;
   assign mcause_diff   = mcause_d;
   assign mtval_diff    = mtval_d;
   assign mscratch_diff = mscratch_d;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Randomised and directed check of csr_trap_ctrl against a CSR-level model
// that tracks architectural register values and the pending redirect.
module tb_csr_trap_ctrl;

   localparam int NS = 2;

   logic        clk = 1'b0;
   logic        reset, wb_valid, except_valid, mret, irq_msip, irq_mtip, irq_meip, redirect_ready;
   logic [63:0] wb_pc, csr_wdata, except_cause, except_tval;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [63:0] csr_rdata, redirect_pc;
   logic        csr_illegal, flush, stall, redirect_valid;
   logic [63:0] mstatus_diff, mie_diff, mip_diff, mtvec_diff, mepc_diff, mcause_diff, mtval_diff, mscratch_diff;

   csr_trap_ctrl #(.XLEN(64), .IRQ_SYNC_STAGES(NS), .HAS_COUNTERS(1'b1)) dut (
      .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .csr_op(csr_op),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata), .except_valid(except_valid),
      .except_cause(except_cause), .except_tval(except_tval), .mret(mret),
      .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
      .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .flush(flush), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
      .mstatus_diff(mstatus_diff), .mie_diff(mie_diff), .mip_diff(mip_diff),
      .mtvec_diff(mtvec_diff), .mepc_diff(mepc_diff), .mcause_diff(mcause_diff),
      .mtval_diff(mtval_diff), .mscratch_diff(mscratch_diff)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic rst, wv; logic [63:0] pc; logic [1:0] op; logic [11:0] addr; logic [63:0] wd;
      logic ev; logic [63:0] ec, et; logic mr; logic [2:0] irq; logic rr;
   } stim_t;

   stim_t s;
   int    n_chk = 0, n_fail = 0;

   // Architectural model state
   logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mcycle, m_minstret, m_rpc;
   logic        m_redir;
   logic [2:0]  hist[$];   // irq input levels seen at each edge, newest first

   // Values observed in the last tick, for literal checks
   logic [63:0] c_rdata, c_rpc, c_mstatus_d, c_mcause_d, c_mepc_d, c_mtval_d;
   logic        c_ill, c_flush, c_stall, c_rv;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] expand(input logic [2:0] b);
      return (64'(b[2]) << 11) | (64'(b[1]) << 7) | (64'(b[0]) << 3);
   endfunction

   task automatic model_reset();
      m_mstatus = 64'h1800; m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
      m_mcause = 0; m_mtval = 0; m_mcycle = 0; m_minstret = 0; m_rpc = 0; m_redir = 0;
      hist.delete();
   endtask

   task automatic tick();
      logic [63:0] mip, nmip, old, nv, pend, tgt, base;
      logic [63:0] n_mstatus, n_mie, n_mtvec, n_mscratch, n_mepc, n_mcause, n_mtval, n_mcycle, n_minstret, n_rpc;
      logic        known, ill, irq, trap, mr, we, idle, n_redir;
      logic [3:0]  code;
      @(negedge clk);
      reset = s.rst; wb_valid = s.wv; wb_pc = s.pc; csr_op = s.op; csr_addr = s.addr;
      csr_wdata = s.wd; except_valid = s.ev; except_cause = s.ec; except_tval = s.et;
      mret = s.mr; {irq_meip, irq_mtip, irq_msip} = s.irq; redirect_ready = s.rr;
      #1;
      c_rdata = csr_rdata; c_rpc = redirect_pc; c_mstatus_d = mstatus_diff; c_mcause_d = mcause_diff;
      c_mepc_d = mepc_diff; c_mtval_d = mtval_diff; c_ill = csr_illegal; c_flush = flush;
      c_stall = stall; c_rv = redirect_valid;

      mip  = (hist.size() >= NS) ? expand(hist[NS-1]) : 64'h0;
      nmip = (NS == 1) ? expand(s.irq) : ((hist.size() >= NS-1) ? expand(hist[NS-2]) : 64'h0);
      known = 1'b1;
      case (s.addr)
         12'h300: old = m_mstatus;   12'h304: old = m_mie;      12'h305: old = m_mtvec;
         12'h340: old = m_mscratch;  12'h341: old = m_mepc;     12'h342: old = m_mcause;
         12'h343: old = m_mtval;     12'h344: old = mip;        12'hB00: old = m_mcycle;
         12'hB02: old = m_minstret;  12'hF14: old = 0;
         default: begin old = 0; known = 1'b0; end
      endcase
      ill  = (s.op != 0) && (!known || s.addr >= 12'hC00);
      pend = mip & m_mie;
      irq  = m_mstatus[3] && (pend != 0);
      code = pend[11] ? 4'd11 : (pend[3] ? 4'd3 : 4'd7);
      idle = !m_redir;
      trap = s.wv && idle && (irq || s.ev);
      mr   = s.wv && idle && s.mr && !trap;
      we   = s.wv && idle && !trap && s.op != 0 && !ill;
      nv   = (s.op == 1) ? s.wd : (s.op == 2) ? (old | s.wd) : (old & ~s.wd);

      n_mstatus = m_mstatus; n_mie = m_mie; n_mtvec = m_mtvec; n_mscratch = m_mscratch;
      n_mepc = m_mepc; n_mcause = m_mcause; n_mtval = m_mtval; tgt = 0;
      base = {m_mtvec[63:2], 2'b00};
      if (trap) begin
         n_mepc    = {s.pc[63:2], 2'b00};
         n_mcause  = irq ? ((64'h1 << 63) | 64'(code)) : s.ec;
         n_mtval   = irq ? 64'h0 : s.et;
         n_mstatus = 64'h1800 | (m_mstatus[3] ? 64'h80 : 64'h0);
         tgt       = (irq && m_mtvec[1:0] == 2'b01) ? base + 4 * 64'(code) : base;
      end else if (mr) begin
         n_mstatus = 64'h1880 | (m_mstatus[7] ? 64'h8 : 64'h0);
         tgt       = m_mepc;
      end else if (we) begin
         case (s.addr)
            12'h300: n_mstatus  = 64'h1800 | (nv & 64'h88);
            12'h304: n_mie      = nv & 64'h888;
            12'h305: n_mtvec    = nv;
            12'h340: n_mscratch = nv;
            12'h341: n_mepc     = nv & ~64'h3;
            12'h342: n_mcause   = nv;
            12'h343: n_mtval    = nv;
            default: ;
         endcase
      end
      n_mcycle   = (we && s.addr == 12'hB00) ? nv : m_mcycle + 1;
      n_minstret = (we && s.addr == 12'hB02) ? nv : m_minstret + ((s.wv && idle && !trap) ? 1 : 0);
      n_redir    = m_redir ? !s.rr : (trap || mr);
      n_rpc      = (trap || mr) ? tgt : m_rpc;

      if (!s.rst) begin
         if (known) chk("rdata", csr_rdata, old);
         if (s.op != 0) chk("illegal", 64'(csr_illegal), 64'(ill));
         chk("flush", 64'(flush), 64'(trap || mr));
         chk("stall", 64'(stall), 64'(m_redir));
         chk("redirect_valid", 64'(redirect_valid), 64'(m_redir));
         if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
         chk("mstatus_diff", mstatus_diff, n_mstatus);
         chk("mie_diff", mie_diff, n_mie);
         chk("mip_diff", mip_diff, nmip);
         chk("mtvec_diff", mtvec_diff, n_mtvec);
         chk("mepc_diff", mepc_diff, n_mepc);
         chk("mcause_diff", mcause_diff, n_mcause);
         chk("mtval_diff", mtval_diff, n_mtval);
         chk("mscratch_diff", mscratch_diff, n_mscratch);
      end

      @(posedge clk);
      if (s.rst) model_reset();
      else begin
         m_mstatus = n_mstatus; m_mie = n_mie; m_mtvec = n_mtvec; m_mscratch = n_mscratch;
         m_mepc = n_mepc; m_mcause = n_mcause; m_mtval = n_mtval; m_mcycle = n_mcycle;
         m_minstret = n_minstret; m_redir = n_redir; m_rpc = n_rpc;
         hist.push_front(s.irq);
         if (hist.size() > NS) void'(hist.pop_back());
      end
   endtask

   task automatic quiet();
      s.rst = 0; s.wv = 0; s.op = 0; s.ev = 0; s.mr = 0; s.rr = 0; s.wd = 0; s.ec = 0; s.et = 0;
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
      quiet(); s.wv = 1; s.op = 2'b01; s.addr = a; s.wd = d; tick();
   endtask

   task automatic rd(input logic [11:0] a);
      quiet(); s.addr = a; tick();
   endtask

   task automatic wait_n(input int n);
      for (int i = 0; i < n; i++) begin quiet(); tick(); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   logic [63:0] v0;
   logic [11:0] addrs[13] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                              12'h344, 12'hB00, 12'hB02, 12'hF14, 12'h7C0, 12'hF11};

   initial begin
      s = '0;
      s.rst = 1; tick(); tick();

      rd(12'h300);                         chk("reset_mstatus", c_rdata, 64'h1800);
      quiet(); s.wv = 1; s.op = 2'b10; s.addr = 12'h300; s.wd = 64'h8; tick();
      rd(12'h300);                         chk("rs_mstatus", c_rdata, 64'h1808);
      csr_wr(12'hF14, 64'h5);              chk("hartid_illegal", 64'(c_ill), 64'h1);
      rd(12'hF14);                         chk("hartid_ro", c_rdata, 64'h0);

      // Timer interrupt, vectored mtvec
      csr_wr(12'h305, 64'h8001);
      csr_wr(12'h304, 64'h80);
      s.irq = 3'b010; wait_n(3);
      quiet(); s.wv = 1; s.pc = 64'h1000; tick();
      chk("mti_flush", 64'(c_flush), 64'h1);
      chk("mti_mcause", c_mcause_d, 64'h8000_0000_0000_0007);
      chk("mti_mepc", c_mepc_d, 64'h1000);
      s.irq = 3'b000; quiet(); s.rr = 1; tick();
      chk("mti_rv", 64'(c_rv), 64'h1);
      chk("mti_vec", c_rpc, 64'h801C);
      wait_n(3);
      rd(12'hB02); v0 = c_rdata;
      quiet(); s.wv = 1; s.mr = 1; s.pc = 64'h801C; tick();
      chk("mret_flush", 64'(c_flush), 64'h1);
      chk("mret_mstatus", c_mstatus_d, 64'h1888);
      quiet(); s.rr = 1; tick();
      chk("mret_target", c_rpc, 64'h1000);
      rd(12'hB02);                         chk("mret_minstret", c_rdata, v0 + 1);

      // All three interrupts plus a same-cycle exception
      csr_wr(12'h304, 64'h888);
      s.irq = 3'b111; wait_n(3);
      quiet(); s.wv = 1; s.pc = 64'h3000; s.ev = 1; s.ec = 2; s.et = 64'hDEAD; tick();
      chk("mei_mcause", c_mcause_d, 64'h8000_0000_0000_000B);
      chk("mei_mtval", c_mtval_d, 64'h0);
      quiet(); s.rr = 1; tick();
      chk("mei_vec", c_rpc, 64'h802C);
      s.irq = 3'b000; wait_n(3);

      // ecall with fetch back-pressure
      quiet(); s.wv = 1; s.pc = 64'h2004; s.ev = 1; s.ec = 11; tick();
      chk("ecall_mcause", c_mcause_d, 64'd11);
      chk("ecall_mepc", c_mepc_d, 64'h2004);
      for (int i = 0; i < 3; i++) begin
         quiet(); tick();
         chk("ecall_hold_rv", 64'(c_rv), 64'h1);
         chk("ecall_hold_stall", 64'(c_stall), 64'h1);
      end
      quiet(); s.rr = 1; tick();           chk("ecall_rv_last", 64'(c_rv), 64'h1);
      chk("ecall_vec", c_rpc, 64'h8000);
      quiet(); tick();                     chk("ecall_rv_drop", 64'(c_rv), 64'h0);
      chk("ecall_stall_drop", 64'(c_stall), 64'h0);

      // mcycle wrap
      csr_wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
      rd(12'hB00);                         chk("mcycle_written", c_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
      rd(12'hB00);                         chk("mcycle_wrap", c_rdata, 64'h0);

      // Reset while redirecting
      quiet(); s.wv = 1; s.pc = 64'h4000; s.ev = 1; s.ec = 3; tick();
      quiet(); tick();                     chk("pre_reset_rv", 64'(c_rv), 64'h1);
      quiet(); s.rst = 1; tick();
      rd(12'h300);                         chk("post_reset_rv", 64'(c_rv), 64'h0);
      chk("post_reset_stall", 64'(c_stall), 64'h0);
      chk("post_reset_mstatus", c_rdata, 64'h1800);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         quiet();
         for (int b = 0; b < 3; b++) if ($urandom_range(0, 39) == 0) s.irq[b] = ~s.irq[b];
         s.addr = addrs[$urandom_range(0, 12)];
         s.op   = 2'($urandom_range(0, 3));
         s.wd   = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 16'hFFFF));
         s.pc   = {$urandom, $urandom};
         s.wv   = !m_redir && ($urandom_range(0, 9) < 6);
         s.ev   = ($urandom_range(0, 11) == 0);
         s.ec   = 64'($urandom_range(0, 15));
         s.et   = {$urandom, $urandom};
         s.mr   = ($urandom_range(0, 14) == 0);
         if (s.mr) s.op = 0;
         s.rr   = $urandom_range(0, 1) == 1;
         s.rst  = ($urandom_range(0, 399) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
